// File: rtl/aes_pkg.sv
// Shared AES helpers: FSM encoding, GF(2^8) arithmetic, S-box, Rcon and
// the round/word-count derivation from the key length.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_t;

  function automatic int num_rounds(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic int num_key_words(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // General GF(2^8) product, only needed to build the S-box inverse.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] p;
    t = x;
    p = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      p = gf_mul(p, t);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]}
             ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  // Rcon[idx] built by repeated xtime from 0x01, so it never needs a table.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < 15; k++) begin
      if (k < int'(idx)) r = xtime(r);
    end
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte i of the block lives at [127-8i -: 8] (row i%4, col i/4).
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign sb[gi] = sbox(state[127-8*gi -: 8]);
    // Row r is rotated left by r columns.
    assign sr[gi] = sb[(((gi / 4) + (gi % 4)) % 4) * 4 + (gi % 4)];
    // The last round skips MixColumns.
    assign next_state[127-8*gi -: 8] = (final_round ? sr[gi] : mc[gi])
                                     ^ round_key[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*gi];
    assign a1 = sr[4*gi+1];
    assign a2 = sr[4*gi+2];
    assign a3 = sr[4*gi+3];
    assign mc[4*gi]   = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
    assign mc[4*gi+1] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
    assign mc[4*gi+2] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
    assign mc[4*gi+3] = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys produced
// on the fly from a sliding Nk-word window of the expanded key.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                i_clock,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [0:127]        i_plain,
  input  logic [0:KEY_BITS-1] i_key,
  output logic                o_busy,
  output logic                o_valid,
  output logic [0:127]        o_cipher
);

  localparam int NR = num_rounds(KEY_BITS);
  localparam int NK = num_key_words(KEY_BITS);
  localparam int KW = 32 * NK;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  fsm_t          fsm;
  logic [127:0]  state;
  logic [KW-1:0] kwin;       // word 0 of the window sits in the top 32 bits
  logic [3:0]    round;

  logic [127:0]  plain_d;
  logic [KW-1:0] key_d;
  logic [KW-1:0] kwin_next;
  logic [127:0]  round_key;
  logic [127:0]  round_out;
  logic          final_round;

  logic [31:0]   win_word [NK];
  logic [31:0]   new_word [4];
  logic [31:0]   temp_word;
  logic [127:0]  new_block;

  assign plain_d     = i_plain;
  assign key_d       = i_key;
  assign final_round = (round == 4'(NR));

  for (genvar gi = 0; gi < NK; gi++) begin : g_win
    assign win_word[gi] = kwin[KW-1-32*gi -: 32];
  end

  // Four fresh schedule words: w[i] = w[i-Nk] ^ temp, chained within the group.
  assign new_word[0] = win_word[0] ^ temp_word;
  for (genvar gi = 1; gi < 4; gi++) begin : g_chain
    assign new_word[gi] = win_word[gi] ^ new_word[gi-1];
  end
  assign new_block = {new_word[0], new_word[1], new_word[2], new_word[3]};

  if (NK == 4) begin : g_k128
    // Window holds RK[round-1]; the new group is this round's key.
    assign temp_word = sub_word(rot_word(win_word[3])) ^ {rcon(round), 24'h0};
    assign kwin_next = new_block;
    assign round_key = new_block;
  end else begin : g_k256
    // Window holds w[4(round-1) .. 4(round-1)+7]; its upper half is this
    // round's key. Odd rounds generate a group starting on a multiple of 8
    // (Rcon step), even rounds the SubWord-only group.
    assign temp_word = round[0]
                     ? (sub_word(rot_word(win_word[7])) ^ {rcon((round + 4'd1) >> 1), 24'h0})
                     : sub_word(win_word[7]);
    assign kwin_next = {kwin[127:0], new_block};
    assign round_key = kwin[127:0];
  end

  aes_round u_round (
    .state      (state),
    .round_key  (round_key),
    .final_round(final_round),
    .next_state (round_out)
  );

  // Control FSM with registered busy/valid/cipher and the round datapath.
  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      fsm      <= ST_IDLE;
      state    <= '0;
      kwin     <= '0;
      round    <= '0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_cipher <= '0;
    end else begin
      o_valid <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (i_start) begin
            state  <= plain_d ^ key_d[KW-1 -: 128];
            kwin   <= key_d;
            round  <= 4'd1;
            o_busy <= 1'b1;
            fsm    <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state <= round_out;
          kwin  <= kwin_next;
          round <= round + 4'd1;
          if (final_round) begin
            o_cipher <= round_out;
            o_valid  <= 1'b1;
            o_busy   <= 1'b0;
            fsm      <= ST_DONE;
          end
        end
        ST_DONE: begin
          round <= '0;
          fsm   <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: AES-128 and AES-256 instances run side by side
// against a byte-array FIPS-197 reference and a start/accept schedule model.
module tb_aes_iter_core;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] plain_v;
  logic [255:0] key_v;
  logic         busy128, valid128, busy256, valid256;
  logic [127:0] cipher128, cipher256;

  aes_iter_core #(.KEY_BITS(128)) dut128 (
    .i_clock (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_plain (plain_v),
    .i_key   (key_v[255:128]),
    .o_busy  (busy128),
    .o_valid (valid128),
    .o_cipher(cipher128)
  );

  aes_iter_core #(.KEY_BITS(256)) dut256 (
    .i_clock (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_plain (plain_v),
    .i_key   (key_v),
    .o_busy  (busy256),
    .o_valid (valid256),
    .o_cipher(cipher256)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference AES ----------------
  logic [7:0] sbox_tb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // Walk all non-zero elements as powers of 3, tracking the inverse alongside.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word_tb(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input int nk);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] out;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word_tb({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word_tb(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tb[s[i]];
      for (int i = 0; i < 16; i++) s[i] = t[(((i/4) + (i%4)) % 4) * 4 + (i%4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- schedule model (index 0 = AES-128, 1 = AES-256) ----------------
  int           edge_cnt = 0;
  bit           inflight [2];
  int           acc_edge [2];
  int           free_edge [2];
  logic [127:0] pend [2];
  logic [127:0] exp_cipher [2];
  bit           exp_valid [2];
  bit           exp_busy [2];
  int           valid_cnt [2];
  int           last_valid_edge [2];
  logic [127:0] res128_q [$];
  logic [127:0] res256_q [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      inflight[d] = 1'b0; free_edge[d] = 0; exp_valid[d] = 1'b0;
      exp_busy[d] = 1'b0; exp_cipher[d] = '0;
    end
  endtask

  task automatic model_edge(input int d);
    int nr;
    nr = d ? 14 : 10;
    exp_valid[d] = 1'b0;
    if (rst) begin
      inflight[d] = 1'b0; free_edge[d] = 0; exp_busy[d] = 1'b0; exp_cipher[d] = '0;
      return;
    end
    if (inflight[d] && edge_cnt == acc_edge[d] + nr) begin
      exp_cipher[d] = pend[d];
      exp_valid[d]  = 1'b1;
      inflight[d]   = 1'b0;
    end else if (!inflight[d] && start && edge_cnt >= free_edge[d]) begin
      acc_edge[d]  = edge_cnt;
      free_edge[d] = edge_cnt + nr + 2;
      inflight[d]  = 1'b1;
      pend[d] = d ? aes_ref(plain_v, key_v, 8) : aes_ref(plain_v, {key_v[255:128], 128'h0}, 4);
    end
    exp_busy[d] = inflight[d];
  endtask

  // One clock: advance the model with the inputs the DUT is about to sample,
  // then compare every output just after the edge.
  task automatic step();
    logic b, v;
    logic [127:0] c;
    edge_cnt++;
    for (int d = 0; d < 2; d++) model_edge(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      b = d ? busy256 : busy128;
      v = d ? valid256 : valid128;
      c = d ? cipher256 : cipher128;
      check_value($sformatf("busy%0d@%0d", d ? 256 : 128, edge_cnt), {127'h0, b}, {127'h0, exp_busy[d]});
      check_value($sformatf("valid%0d@%0d", d ? 256 : 128, edge_cnt), {127'h0, v}, {127'h0, exp_valid[d]});
      check_value($sformatf("cipher%0d@%0d", d ? 256 : 128, edge_cnt), c, exp_cipher[d]);
      if (v === 1'b1) begin
        valid_cnt[d]++;
        last_valid_edge[d] = edge_cnt;
        if (d == 0) res128_q.push_back(c);
        else res256_q.push_back(c);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] v1_plain, v2_plain;
  logic [255:0] v1_key, v2_key;
  int start_edge;
  int vc0, vc1;

  initial begin
    build_sbox();
    model_reset();
    rst = 1'b0; start = 1'b0; plain_v = '0; key_v = '0;
    for (int d = 0; d < 2; d++) begin valid_cnt[d] = 0; last_valid_edge[d] = 0; end

    // Reset state
    #2 rst = 1'b1;
    #1;
    check_value("rst_busy128", {127'h0, busy128}, 128'h0);
    check_value("rst_valid256", {127'h0, valid256}, 128'h0);
    check_value("rst_cipher128", cipher128, 128'h0);
    check_value("rst_cipher256", cipher256, 128'h0);
    steps(2);
    rst = 1'b0;
    steps(2);

    // FIPS-197 appendix B vector on AES-128, single start pulse
    plain_v = 128'h3243f6a8885a308d313198a2e0370734;
    key_v   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    start = 1'b1;
    start_edge = edge_cnt + 1;
    vc0 = valid_cnt[0];
    step();
    start = 1'b0;
    steps(20);
    check_value("kat1_cipher128", cipher128, 128'h3925841d02dc09fbdc118597196a0b32);
    check_value("kat1_lat128", 128'(last_valid_edge[0] - start_edge), 128'd10);
    check_value("kat1_pulses128", 128'(valid_cnt[0] - vc0), 128'd1);

    // FIPS-197 appendix C vectors: AES-128 and AES-256 share the key prefix
    plain_v = 128'h00112233445566778899aabbccddeeff;
    key_v   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    start = 1'b1;
    start_edge = edge_cnt + 1;
    step();
    start = 1'b0;
    steps(20);
    check_value("kat2_cipher128", cipher128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check_value("kat3_cipher256", cipher256, 128'h8ea2b7ca516745bfeafc49904b496089);
    check_value("kat3_lat256", 128'(last_valid_edge[1] - start_edge), 128'd14);

    // Output hold while idle with random inputs
    vc0 = valid_cnt[0]; vc1 = valid_cnt[1];
    for (int i = 0; i < 20; i++) begin
      plain_v = rand128();
      key_v   = {rand128(), rand128()};
      step();
    end
    check_value("hold_cipher128", cipher128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check_value("hold_cipher256", cipher256, 128'h8ea2b7ca516745bfeafc49904b496089);
    check_value("hold_valid128", 128'(valid_cnt[0] - vc0), 128'd0);
    check_value("hold_valid256", 128'(valid_cnt[1] - vc1), 128'd0);

    // Continuous start; inputs switch to vector 2 three cycles in
    v1_plain = rand128(); v1_key = {rand128(), rand128()};
    v2_plain = rand128(); v2_key = {rand128(), rand128()};
    res128_q.delete(); res256_q.delete();
    plain_v = v1_plain; key_v = v1_key; start = 1'b1;
    steps(3);
    plain_v = v2_plain; key_v = v2_key;
    steps(37);
    // 40 edges from the first accept: results at +10/+22/+34 and +14/+30
    check_value("stress_n128", 128'(res128_q.size()), 128'd3);
    check_value("stress_n256", 128'(res256_q.size()), 128'd2);
    if (res128_q.size() >= 2 && res256_q.size() >= 2) begin
      check_value("stress_r1_128", res128_q[0], aes_ref(v1_plain, {v1_key[255:128], 128'h0}, 4));
      check_value("stress_r2_128", res128_q[1], aes_ref(v2_plain, {v2_key[255:128], 128'h0}, 4));
      check_value("stress_r1_256", res256_q[0], aes_ref(v1_plain, v1_key, 8));
      check_value("stress_r2_256", res256_q[1], aes_ref(v2_plain, v2_key, 8));
    end else begin
      check_value("stress_results_present", 128'h0, 128'h1);
    end
    start = 1'b0;
    steps(20);

    // Asynchronous reset in the middle of a block
    plain_v = rand128(); key_v = {rand128(), rand128()};
    start = 1'b1;
    step();
    start = 1'b0;
    steps(5);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_value("arst_busy128", {127'h0, busy128}, 128'h0);
    check_value("arst_busy256", {127'h0, busy256}, 128'h0);
    check_value("arst_valid128", {127'h0, valid128}, 128'h0);
    check_value("arst_valid256", {127'h0, valid256}, 128'h0);
    check_value("arst_cipher128", cipher128, 128'h0);
    check_value("arst_cipher256", cipher256, 128'h0);
    step();
    rst = 1'b0;
    vc0 = valid_cnt[0]; vc1 = valid_cnt[1];
    steps(20);
    check_value("arst_nopulse128", 128'(valid_cnt[0] - vc0), 128'd0);
    check_value("arst_nopulse256", 128'(valid_cnt[1] - vc1), 128'd0);
    v1_plain = rand128(); v1_key = {rand128(), rand128()};
    plain_v = v1_plain; key_v = v1_key; start = 1'b1;
    step();
    start = 1'b0;
    plain_v = rand128(); key_v = {rand128(), rand128()};
    steps(20);
    check_value("arst_fresh128", cipher128, aes_ref(v1_plain, {v1_key[255:128], 128'h0}, 4));
    check_value("arst_fresh256", cipher256, aes_ref(v1_plain, v1_key, 8));

    // Random starts and inputs every cycle
    for (int i = 0; i < 200; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      plain_v = rand128();
      key_v   = {rand128(), rand128()};
      step();
    end
    start = 1'b0;
    steps(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
